// File: rtl/aes_encryption_iterative.sv
// Iterative AES-128 encryption core: one round per clock over a 128-bit state register.
// Optional `AES_ENC_EARLY_READY_EN` lets a DONE->RUN hand-over accept the next block on the output handshake edge.
module aes_encryption_iterative (
  input  logic           clk,
  input  logic           reset,
  input  logic [0:1407]  round_keys,
  input  logic [127:0]   plaintext,
  input  logic           in_valid,
  output logic           in_ready,
  output logic [127:0]   ciphertext,
  output logic           out_valid,
  input  logic           out_ready,
  output logic           busy,
  output logic [1:0]     dbg_fsm
);

  // Handshakes: a block moves on a rising edge where valid && ready are both
  // high; valid never depends on ready, and data is held stable while valid waits.

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } fsm_e;

  localparam logic [2047:0] SBOX_TABLE = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox(input logic [7:0] x);
    return SBOX_TABLE[8*(255 - int'(x)) +: 8];
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  fsm_e         fsm_q, fsm_d;
  logic [127:0] state_q, state_d;
  logic [3:0]   rnd_q, rnd_d;
  logic         in_ready_q, in_ready_d;
  logic         out_valid_q, out_valid_d;
  logic         busy_q, busy_d;

  logic [127:0] key0;
  logic [127:0] rkey;
  logic [7:0]   sb_b [16];
  logic [7:0]   sr_b [16];
  logic [7:0]   mc_b [16];
  logic [127:0] sr_vec;
  logic [127:0] mc_vec;
  logic [127:0] round_out;

  assign key0 = round_keys[0 +: 128];

  always_comb begin
    rkey = '0;
    for (int r = 1; r < 11; r++) begin
      if (rnd_q == 4'(r)) rkey = round_keys[128*r +: 128];
    end
  end

  // Byte i of the state is [127-8i -: 8]; byte index = row + 4*column.
  always_comb begin
    sb_b   = '{default: '0};
    sr_b   = '{default: '0};
    mc_b   = '{default: '0};
    sr_vec = '0;
    mc_vec = '0;
    for (int i = 0; i < 16; i++) begin
      sb_b[i] = sbox(state_q[127-8*i -: 8]);
    end
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        sr_b[r+4*c] = sb_b[r + 4*((c + r) % 4)];
      end
    end
    for (int c = 0; c < 4; c++) begin
      mc_b[4*c+0] = xtime(sr_b[4*c+0]) ^ xtime(sr_b[4*c+1]) ^ sr_b[4*c+1]
                  ^ sr_b[4*c+2] ^ sr_b[4*c+3];
      mc_b[4*c+1] = sr_b[4*c+0] ^ xtime(sr_b[4*c+1]) ^ xtime(sr_b[4*c+2])
                  ^ sr_b[4*c+2] ^ sr_b[4*c+3];
      mc_b[4*c+2] = sr_b[4*c+0] ^ sr_b[4*c+1] ^ xtime(sr_b[4*c+2])
                  ^ xtime(sr_b[4*c+3]) ^ sr_b[4*c+3];
      mc_b[4*c+3] = xtime(sr_b[4*c+0]) ^ sr_b[4*c+0] ^ sr_b[4*c+1]
                  ^ sr_b[4*c+2] ^ xtime(sr_b[4*c+3]);
    end
    for (int i = 0; i < 16; i++) begin
      sr_vec[127-8*i -: 8] = sr_b[i];
      mc_vec[127-8*i -: 8] = mc_b[i];
    end
  end

  // The final round skips MixColumns.
  assign round_out = ((rnd_q == 4'd10) ? sr_vec : mc_vec) ^ rkey;

  always_comb begin
    fsm_d   = fsm_q;
    state_d = state_q;
    rnd_d   = rnd_q;
    case (fsm_q)
      IDLE: begin
        if (in_valid) begin
          state_d = plaintext ^ key0;
          rnd_d   = 4'd1;
          fsm_d   = RUN;
        end
      end
      RUN: begin
        state_d = round_out;
        if (rnd_q == 4'd10) fsm_d = DONE;
        else                rnd_d = rnd_q + 4'd1;
      end
      DONE: begin
        if (out_ready) begin
`ifdef AES_ENC_EARLY_READY_EN
          if (in_valid) begin
            state_d = plaintext ^ key0;
            rnd_d   = 4'd1;
            fsm_d   = RUN;
          end else begin
            fsm_d = IDLE;
          end
`else
          fsm_d = IDLE;
`endif
        end
      end
      default: fsm_d = IDLE;
    endcase
    in_ready_d  = (fsm_d == IDLE);
    out_valid_d = (fsm_d == DONE);
    busy_d      = (fsm_d != IDLE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fsm_q       <= IDLE;
      state_q     <= '0;
      rnd_q       <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      fsm_q       <= fsm_d;
      state_q     <= state_d;
      rnd_q       <= rnd_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
    end
  end

`ifdef AES_ENC_EARLY_READY_EN
  assign in_ready = in_ready_q | (out_valid_q & out_ready);
`else
  assign in_ready = in_ready_q;
`endif
  assign out_valid  = out_valid_q;
  assign busy       = busy_q;
  assign ciphertext = state_q;
  assign dbg_fsm    = fsm_q;

endmodule

// File: doc/aes_encryption_iterative.md
# aes_encryption_iterative

Iterative AES-128 encryption core that computes one round per clock over a single 128-bit state register, using a precomputed, externally supplied 11-entry round-key schedule. It is the encrypt-direction companion to the team's unrolled decryption datapath: ciphertext it produces, driven with the same `round_keys` vector, decrypts back to the original plaintext. Valid/ready handshakes on input and output let it sit between a plaintext source and a ciphertext sink.

## Interface
Parameters:
- None. AES-128 only: 10 rounds, 128-bit block.

Ports:
- `clk` input 1: the single clock; all state updates on its rising edge.
- `reset` input 1: asynchronous, active-low reset.
- `round_keys` input [0:1407]: round key r occupies `[128*r : 128*r+127]`. Key 0 is the initial AddRoundKey; key 10 is the final round.
- `plaintext` input [127:0]: byte 0 is `[127:120]`; column-major state as in FIPS-197.
- `in_valid` input 1: `plaintext` is valid.
- `in_ready` output 1: the core accepts a block this cycle.
- `ciphertext` output [127:0]: the result, valid while `out_valid` is high.
- `out_valid` output 1: `ciphertext` holds a completed block.
- `out_ready` input 1: the sink takes the block.
- `busy` output 1: high in RUN or DONE.

## Operation
- Registers:
  - `state_reg` [127:0].
  - `rnd` [3:0], range 1..10.
  - `fsm` with states IDLE, RUN, DONE.
- Combinational round function, applied to `state_reg`:
  - SubBytes: 16 forward S-boxes.
  - ShiftRows: row r rotated left by r bytes.
  - MixColumns over GF(2^8), reduction polynomial 0x11B.
  - AddRoundKey with `round_keys[128*rnd +: 128]`.
  - MixColumns is bypassed when `rnd == 10`.
- IDLE:
  - `in_ready` = 1.
  - On `in_valid && in_ready`: `state_reg <= plaintext ^ round_keys[0:127]`, `rnd <= 1`, go to RUN.
- RUN:
  - `state_reg <= round(state_reg, rnd)`.
  - If `rnd == 10`, go to DONE; otherwise `rnd <= rnd + 1`.
  - `in_valid` is ignored.
- DONE:
  - `out_valid` = 1 and `ciphertext` = `state_reg`.
  - Holds indefinitely while `out_ready` = 0; `ciphertext` stays stable.
  - On `out_ready`, go to IDLE.
- `round_keys` must stay stable from the accept cycle until the last RUN cycle. The core does not latch it, and a change mid-block gives undefined ciphertext.
- Reset, asynchronous and at any time including mid-block:
  - `fsm` = IDLE, `state_reg` = 0, `rnd` = 0.
  - `out_valid` = 0, `busy` = 0, `ciphertext` = 0.
  - `in_ready` = 1 once reset is released.
  - An in-flight block is discarded and no output is produced for it.

## Timing
- Reset values:
  - `in_ready` = 1.
  - `out_valid` = 0.
  - `busy` = 0.
  - `ciphertext` = 128'h0.
- Accept at rising edge N:
  - RUN during cycles N+1 through N+10.
  - `out_valid` goes high after edge N+10.
  - Latency from accept to `out_valid` is 10 cycles.
- With `out_ready` held high, the output handshake completes at edge N+11. The earliest next accept is edge N+12 (build without the macro).
- `in_ready` is low in RUN and DONE (without the macro).
- `out_valid` is low in IDLE and RUN.
- No combinational path from `in_valid` to any output.

## Configuration
- `AES_ENC_EARLY_READY_EN` defined:
  - In DONE, `in_ready = out_ready`.
  - A same-edge output handshake and input accept moves DONE directly to RUN and loads the new initial state.
  - Back-to-back throughput is one block per 11 cycles.
- `AES_ENC_EARLY_READY_EN` undefined:
  - `in_ready` is high only in IDLE.
  - Throughput is one block per 12 cycles.
  - No `out_ready`-to-`in_ready` combinational path.

## Test plan
- FIPS-197 C.1: key 000102030405060708090a0b0c0d0e0f (schedule expanded by the bench), plaintext 00112233445566778899aabbccddeeff -> ciphertext 69c4e0d86a7b0430d8cdb78070b4c55a with `out_valid` exactly 10 cycles after accept.
- FIPS-197 Appendix B: key 2b7e151628aed2a6abf7158809cf4f3c, plaintext 3243f6a8885a308d313198a2e0370734 -> 3925841d02dc09fbdc118597196a0b32.
- Backpressure: hold `out_ready` = 0 for 20 cycles in DONE -> `ciphertext` stable, `out_valid` stays high, `in_ready` = 0, and `in_valid` pulses are ignored.
- Back-to-back: 8 random blocks with `in_valid`/`out_ready` held high -> all match the reference model.
  - With `AES_ENC_EARLY_READY_EN`: accepts every 11 cycles.
  - Without it: accepts every 12 cycles.
- Reset mid-block: assert `reset` = 0 at RUN `rnd` = 5 -> outputs take their reset values asynchronously (no clock edge required), no `out_valid` ever appears for that block, and the next block is correct.
- Round trip: encrypt 4 random blocks, then feed each ciphertext with the same `round_keys` to the unrolled decryption datapath -> the original plaintext is recovered.
